// File: rtl/controle_tempo_jogada_pkg.sv
// Shared definitions for the answer-time controller: FSM states and debug codes.
package controle_tempo_jogada_pkg;

   localparam int unsigned DB_LARGURA = 2;

   // The numeric encoding is visible on db_estado and decoded by the debug display.
   typedef enum logic [DB_LARGURA-1:0] {
      OCIOSO    = 2'd0,
      CONTANDO  = 2'd1,
      CONCLUIDO = 2'd2,
      ESGOTADO  = 2'd3
   } estado_t;

   // Maps a state to the code shown on the debug display.
   function automatic logic [DB_LARGURA-1:0] codigo_estado(input estado_t e);
      return e;
   endfunction

endpackage

// File: rtl/controle_tempo_jogada_if.sv
// Handshake between the game control unit (master) and the answer-time controller (slave).
interface controle_tempo_jogada_if
   import controle_tempo_jogada_pkg::*;
#(
   parameter int unsigned LARGURA = 4
);
   logic                  iniciar;
   logic                  parar;
   logic                  ativo;
   logic [LARGURA-1:0]    tempo_restante;
   logic [LARGURA-1:0]    pontos;
   logic                  fim;
   logic                  timeout;
   logic [DB_LARGURA-1:0] db_estado;

   modport master (
      output iniciar, parar,
      input  ativo, tempo_restante, pontos, fim, timeout, db_estado
   );

   modport slave (
      input  iniciar, parar,
      output ativo, tempo_restante, pontos, fim, timeout, db_estado
   );
endinterface

// File: rtl/controle_tempo_jogada_gerador_tick.sv
// Per-second prescaler: counts enabled cycles and flags the last one of each second.
module gerador_tick #(
   parameter int unsigned TICKS_SEG = 50000000
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic habilita,
   output logic tick
);
   localparam int unsigned PW = (TICKS_SEG > 1) ? $clog2(TICKS_SEG) : 1;
   localparam logic [PW-1:0] MAXIMO = PW'(TICKS_SEG - 1);

   logic [PW-1:0] contagem;

   // Prescaler register: clear has priority, then count and wrap at the end of a second.
   always_ff @(posedge clock) begin
      if (reset || zera) begin
         contagem <= '0;
      end else if (habilita) begin
         if (contagem == MAXIMO) begin
            contagem <= '0;
         end else begin
            contagem <= contagem + PW'(1);
         end
      end
   end

   // Tick is combinational so the caller sees it in the wrap cycle itself.
   always_comb begin
      tick = habilita && (contagem == MAXIMO);
   end
endmodule

// File: rtl/controle_tempo_jogada.sv
// Answer-time controller: counts down seconds while waiting for a move and reports
// the seconds left as points, or a timeout, with a one-cycle fim handshake.
module controle_tempo_jogada
   import controle_tempo_jogada_pkg::*;
#(
   parameter int unsigned TICKS_SEG = 50000000,
   parameter int unsigned TEMPO_S   = 10,
   parameter int unsigned LARGURA   = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   controle_tempo_jogada_if.slave  jog
);
   localparam logic [LARGURA-1:0] TEMPO_INI = LARGURA'(TEMPO_S);
   localparam logic [LARGURA-1:0] UM        = LARGURA'(1);

   estado_t            estado, estado_d;
   logic [LARGURA-1:0] restante, restante_d;
   logic [LARGURA-1:0] pontos, pontos_d;
   logic               fim, fim_d;
   logic               esgotou, esgotou_d;
   logic               tick;
   logic               contando;
   logic               zera_pre;

   assign contando = (estado == CONTANDO);
   // The prescaler restarts from 0 on any (re)load and stays cleared outside counting.
   assign zera_pre = !contando || jog.iniciar || jog.parar;

   gerador_tick #(
      .TICKS_SEG (TICKS_SEG)
   ) u_tick (
      .clock    (clock),
      .reset    (reset),
      .zera     (zera_pre),
      .habilita (contando),
      .tick     (tick)
   );

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado   <= OCIOSO;
         restante <= TEMPO_INI;
         pontos   <= '0;
         fim      <= 1'b0;
         esgotou  <= 1'b0;
      end else begin
         estado   <= estado_d;
         restante <= restante_d;
         pontos   <= pontos_d;
         fim      <= fim_d;
         esgotou  <= esgotou_d;
      end
   end

   // Next state and next register values; parar beats iniciar, which beats the tick.
   always_comb begin
      estado_d   = estado;
      restante_d = restante;
      pontos_d   = pontos;
      fim_d      = 1'b0;
      esgotou_d  = 1'b0;
      case (estado)
         OCIOSO: begin
            if (jog.iniciar) begin
               estado_d   = CONTANDO;
               restante_d = TEMPO_INI;
            end
         end
         CONTANDO: begin
            if (jog.parar) begin
               estado_d = CONCLUIDO;
               pontos_d = restante;
               fim_d    = 1'b1;
            end else if (jog.iniciar) begin
               restante_d = TEMPO_INI;
            end else if (tick) begin
               if (restante <= UM) begin
                  estado_d   = ESGOTADO;
                  restante_d = '0;
                  pontos_d   = '0;
                  fim_d      = 1'b1;
                  esgotou_d  = 1'b1;
               end else begin
                  restante_d = restante - UM;
               end
            end
         end
         CONCLUIDO, ESGOTADO: begin
            if (jog.iniciar) begin
               estado_d   = CONTANDO;
               restante_d = TEMPO_INI;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   // Outputs come straight from registers.
   always_comb begin
      jog.ativo          = contando;
      jog.tempo_restante = restante;
      jog.pontos         = pontos;
      jog.fim            = fim;
      jog.timeout        = esgotou;
      jog.db_estado      = codigo_estado(estado);
   end
endmodule
